// File: rtl/branch_sequencer.sv
// Fetch/branch sequencer for the 8-bit CPU: owns the PC, fetches instruction bytes,
// issues non-conditional instructions and resolves condition-mode jumps.
module branch_sequencer #(
    parameter int unsigned       ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [7:0]        imem_rsp_data,
    output logic              instr_valid,
    output logic [7:0]        instr,
    input  logic              exec_ready,
    output logic [2:0]        cond_opcode,
    output logic [7:0]        cond_operand,
    input  logic              cond_result,
    input  logic [7:0]        reg3_value,
    input  logic [7:0]        jump_target,
    input  logic              halt,
    output logic              halted,
    output logic              branch_taken,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_COND  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    logic [2:0]        state;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jump_pc;

    assign pc_inc  = pc + ADDR_W'(1);
    // Cast truncates or zero-extends the 8-bit register to the PC width.
    assign jump_pc = ADDR_W'(jump_target);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            pc           <= RESET_PC;
            instr        <= '0;
            branch_taken <= 1'b0;
        end else begin
            branch_taken <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (halt)
                        state <= S_HALT;
                    else if (imem_req_ready)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        instr <= imem_rsp_data;
                        state <= (imem_rsp_data[7:6] == 2'b11) ? S_COND : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (exec_ready) begin
                        pc    <= pc_inc;
                        state <= S_FETCH;
                    end
                end
                S_COND: begin
                    if (cond_result) begin
                        pc           <= jump_pc;
                        branch_taken <= 1'b1;
                    end else begin
                        pc <= pc_inc;
                    end
                    state <= S_FETCH;
                end
                S_HALT: begin
                    if (!halt)
                        state <= S_FETCH;
                end
                default: state <= S_FETCH;
            endcase
        end
    end

    // Reset holds the state at FETCH, so the request is gated to stay low during reset.
    assign imem_req_valid = rst_n && (state == S_FETCH) && !halt;
    assign imem_addr      = pc;
    assign instr_valid    = (state == S_ISSUE);
    assign halted         = (state == S_HALT);
    assign cond_opcode    = (state == S_COND) ? instr[2:0] : 3'd0;
    assign cond_operand   = reg3_value;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios plus a randomized run, checked
// against a transaction-level model of the program flow.
module tb_branch_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_req_valid;
    logic       imem_req_ready = 1'b0;
    logic [7:0] imem_addr;
    logic       imem_rsp_valid = 1'b0;
    logic [7:0] imem_rsp_data = 8'h00;
    logic       instr_valid;
    logic [7:0] instr;
    logic       exec_ready = 1'b0;
    logic [2:0] cond_opcode;
    logic [7:0] cond_operand;
    logic       cond_result = 1'b0;
    logic [7:0] reg3_value = 8'h00;
    logic [7:0] jump_target = 8'h00;
    logic       halt = 1'b0;
    logic       halted;
    logic       branch_taken;
    logic [7:0] pc;

    branch_sequencer #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid), .instr(instr),
        .exec_ready(exec_ready), .cond_opcode(cond_opcode), .cond_operand(cond_operand),
        .cond_result(cond_result), .reg3_value(reg3_value), .jump_target(jump_target),
        .halt(halt), .halted(halted), .branch_taken(branch_taken), .pc(pc)
    );

    initial forever #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    // Program memory and stimulus knobs
    logic [7:0] mem [256];
    int p_ready, p_exec, lat_k, max_lat, p_junk, r3_k, tgt_k;
    bit rand_halt, halt_k, force_junk;
    logic [7:0] junk_data;

    // Reference model: architectural PC plus where the current instruction is in flight
    logic [7:0] m_pc, m_byte;
    bit m_wait, m_issue, m_cond, exp_bt, halt_prev, busy_prev;
    int m_lat;
    int unsigned n_ret;
    logic [7:0] flog[$];
    logic [7:0] ilog[$];
    int unsigned bt_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit eval_cond(input logic [2:0] op, input logic [7:0] v);
        case (op)
            3'd0: return 1'b0;
            3'd1: return v == 8'h00;
            3'd2: return v != 8'h00;
            3'd3: return v[7];
            3'd4: return 1'b1;
            3'd5: return !v[7];
            3'd6: return v[0];
            default: return !v[0];
        endcase
    endfunction

    task automatic cyc();
        bit busy, ex_halted, ex_rv, rsp_now, res;
        if (rand_halt) begin
            if ($urandom_range(99) < 4) halt = !halt;
        end else begin
            halt = halt_k;
        end
        imem_req_ready = ($urandom_range(99) < p_ready);
        exec_ready     = ($urandom_range(99) < p_exec);
        reg3_value     = (r3_k < 0)  ? 8'($urandom) : 8'(r3_k);
        jump_target    = (tgt_k < 0) ? 8'($urandom) : 8'(tgt_k);
        rsp_now        = 1'b0;
        imem_rsp_data  = 8'($urandom);
        if (m_wait) begin
            if (m_lat == 0) begin
                rsp_now       = 1'b1;
                imem_rsp_data = mem[m_pc];
            end else begin
                m_lat--;
            end
        end else if (force_junk) begin
            rsp_now       = 1'b1;
            imem_rsp_data = junk_data;
        end else if ($urandom_range(99) < p_junk) begin
            rsp_now = 1'b1;
        end
        imem_rsp_valid = rsp_now;
        res = m_cond ? eval_cond(m_byte[2:0], reg3_value) : 1'($urandom);
        cond_result = res;

        @(negedge clk);
        busy      = m_wait || m_issue || m_cond;
        ex_halted = !busy && !busy_prev && halt_prev;
        ex_rv     = !busy && !halt && !ex_halted;
        chk("req_valid", imem_req_valid, ex_rv);
        if (ex_rv) begin
            chk("fetch_addr", imem_addr, m_pc);
            chk("pc", pc, m_pc);
        end
        chk("halted", halted, ex_halted);
        chk("instr_valid", instr_valid, m_issue);
        if (m_issue) chk("instr", instr, m_byte);
        chk("cond_opcode", cond_opcode, m_cond ? m_byte[2:0] : 3'd0);
        if (m_cond) chk("cond_operand", cond_operand, reg3_value);
        chk("branch_taken", branch_taken, exp_bt);
        if (branch_taken) bt_cnt++;

        halt_prev = halt;
        busy_prev = busy;
        exp_bt    = 1'b0;
        if (ex_rv && imem_req_ready) begin
            flog.push_back(imem_addr);
            m_wait = 1'b1;
            m_lat  = (lat_k >= 0) ? lat_k : int'($urandom_range(max_lat));
        end else if (m_wait && rsp_now) begin
            m_wait  = 1'b0;
            m_byte  = imem_rsp_data;
            m_cond  = (imem_rsp_data[7:6] == 2'b11);
            m_issue = !m_cond;
        end else if (m_issue && exec_ready) begin
            ilog.push_back(instr);
            m_issue = 1'b0;
            m_pc    = m_pc + 8'd1;
            n_ret++;
        end else if (m_cond) begin
            m_cond = 1'b0;
            if (res) begin
                m_pc   = jump_target;
                exp_bt = 1'b1;
            end else begin
                m_pc = m_pc + 8'd1;
            end
            n_ret++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        imem_rsp_valid = 1'b0;
        halt           = 1'b0;
        #2;
        chk("rst_req_valid", imem_req_valid, 1'b0);
        chk("rst_instr_valid", instr_valid, 1'b0);
        chk("rst_branch_taken", branch_taken, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cond_opcode", cond_opcode, 3'd0);
        chk("rst_pc", pc, 8'h00);
        chk("rst_instr", instr, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        p_ready = 100; p_exec = 100; lat_k = 0; max_lat = 0; p_junk = 0;
        r3_k = -1; tgt_k = -1; rand_halt = 1'b0; halt_k = 1'b0; force_junk = 1'b0;
        junk_data = 8'h00;
        m_pc = 8'h00; m_byte = 8'h00; m_wait = 1'b0; m_issue = 1'b0; m_cond = 1'b0;
        exp_bt = 1'b0; halt_prev = 1'b0; busy_prev = 1'b0; m_lat = 0; n_ret = 0;
        flog.delete(); ilog.delete(); bt_cnt = 0;
    endtask

    initial begin
        // Straight-line program, zero-wait memory and execute
        do_reset();
        mem[0] = 8'h00; mem[1] = 8'h41; mem[2] = 8'h82;
        run(10);
        chk("seq_fetch_count", flog.size(), 4);
        chk("seq_fetch0", flog[0], 8'h00);
        chk("seq_fetch1", flog[1], 8'h01);
        chk("seq_fetch2", flog[2], 8'h02);
        chk("seq_fetch3", flog[3], 8'h03);
        chk("seq_issue_count", ilog.size(), 3);
        chk("seq_issue0", ilog[0], 8'h00);
        chk("seq_issue1", ilog[1], 8'h41);
        chk("seq_issue2", ilog[2], 8'h82);
        chk("seq_no_branch", bt_cnt, 0);

        // Unconditional jump to 0x10, then 0xC4 there jumping to 0x37
        do_reset();
        mem[8'h00] = 8'hC4; mem[8'h10] = 8'hC4;
        tgt_k = 8'h10;
        run(3);
        tgt_k = 8'h37;
        run(4);
        chk("jmp_fetch_count", flog.size(), 3);
        chk("jmp_fetch1", flog[1], 8'h10);
        chk("jmp_fetch2", flog[2], 8'h37);
        chk("jmp_bt_pulses", bt_cnt, 2);

        // 0xC1 (==0): falls through with reg3=5, jumps with reg3=0
        do_reset();
        mem[8'h00] = 8'hC4; mem[8'h20] = 8'hC1; mem[8'h21] = 8'hC1;
        tgt_k = 8'h20; r3_k = 8'h05;
        run(6);
        tgt_k = 8'h50; r3_k = 8'h00;
        run(4);
        chk("eq0_fetch_count", flog.size(), 4);
        chk("eq0_fall_through", flog[2], 8'h21);
        chk("eq0_taken", flog[3], 8'h50);
        chk("eq0_bt_pulses", bt_cnt, 2);

        // PC wrap from 0xFF to 0x00
        do_reset();
        mem[8'h00] = 8'hC4; mem[8'hFF] = 8'h12;
        tgt_k = 8'hFF;
        run(7);
        chk("wrap_fetch_count", flog.size(), 3);
        chk("wrap_fetch1", flog[1], 8'hFF);
        chk("wrap_fetch2", flog[2], 8'h00);
        chk("wrap_issue", ilog[0], 8'h12);

        // Memory stall then execute stall
        do_reset();
        mem[0] = 8'h15;
        p_ready = 0;
        run(4);
        p_ready = 100; p_exec = 0;
        run(5);
        p_exec = 100;
        run(1);
        chk("stall_pc", pc, 8'h01);
        chk("stall_issue_count", ilog.size(), 1);
        chk("stall_fetch_count", flog.size(), 1);

        // Halt raised during ISSUE
        do_reset();
        mem[0] = 8'h22; mem[1] = 8'h00;
        p_exec = 0;
        run(3);
        halt_k = 1'b1;
        run(1);
        p_exec = 100;
        run(4);
        chk("halt_halted", halted, 1'b1);
        chk("halt_no_req", imem_req_valid, 1'b0);
        chk("halt_retired", ilog.size(), 1);
        halt_k = 1'b0;
        run(2);
        chk("halt_fetch_count", flog.size(), 2);
        chk("halt_resume_addr", flog[1], 8'h01);

        // Reset during WAIT, then a stale response
        do_reset();
        mem[0] = 8'h77;
        lat_k = 3;
        run(2);
        do_reset();
        mem[0] = 8'h33;
        p_ready = 0; force_junk = 1'b1; junk_data = 8'hC4;
        run(2);
        force_junk = 1'b0; p_ready = 100;
        run(4);
        chk("rstwait_fetch0", flog[0], 8'h00);
        chk("rstwait_issue_count", ilog.size(), 1);
        chk("rstwait_issue0", ilog[0], 8'h33);
        chk("rstwait_no_branch", bt_cnt, 0);

        // Randomized program, handshakes, latencies, junk responses and halts
        do_reset();
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        p_ready = 70; p_exec = 70; lat_k = -1; max_lat = 2; p_junk = 20;
        rand_halt = 1'b1;
        run(3000);
        chk("random_progress", n_ret > 200, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
- Fetch/branch sequencer of the 8-bit CPU.
- Owns the program counter (PC) and fetches instruction bytes from program memory over a valid/ready request/response handshake.
- Hands non-conditional instructions to the execute datapath.
- For condition-mode instructions (bits[7:6]=2'b11), drives the condition opcode and operand to the combinational condition evaluator, samples its result, and either jumps to the target register or falls through.

Parameters:
ADDR_W, 8, PC / instruction-address width.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst_n  input  1  asynchronous, active-low reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts request this cycle.
imem_addr  output  ADDR_W  fetch address (= PC).
imem_rsp_valid  input  1  instruction byte returned this cycle.
imem_rsp_data  input  8  instruction byte.
instr_valid  output  1  non-conditional instruction offered to execute.
instr  output  8  held instruction byte.
exec_ready  input  1  execute accepts instruction this cycle.
cond_opcode  output  3  condition code to evaluator (instr[2:0]).
cond_operand  output  8  value under test to evaluator (register 3).
cond_result  input  1  evaluator output, combinational from the two above.
reg3_value  input  8  current register 3 contents.
jump_target  input  8  current register 0 contents (branch destination).
halt  input  1  level request to stop fetching.
halted  output  1  sequencer stopped.
branch_taken  output  1  one-cycle pulse when a jump is taken.
pc  output  ADDR_W  current PC.

Behaviour:
- States: FETCH, WAIT, ISSUE, COND, HALT.
- Reset (async, rst_n=0):
  - State goes to FETCH, pc=RESET_PC, instr=0.
  - All other outputs are 0: imem_req_valid, instr_valid, branch_taken, halted, cond_opcode.
  - Reset mid-operation abandons any in-flight fetch or issue.
- FETCH:
  - If halt=1, go to HALT; no request is issued.
  - Otherwise imem_req_valid=1 and imem_addr=pc, held stable until imem_req_ready=1; then go to WAIT.
- WAIT:
  - On imem_rsp_valid=1, capture imem_rsp_data into instr.
  - If imem_rsp_data[7:6]==2'b11, go to COND; otherwise go to ISSUE.
  - imem_rsp_valid is ignored in every state except WAIT, so a stale response after reset is dropped.
- ISSUE:
  - instr_valid=1 with instr stable until exec_ready=1.
  - On the handshake cycle: pc <= pc+1, go to FETCH.
- COND (exactly one cycle):
  - cond_opcode=instr[2:0], cond_operand=reg3_value.
  - cond_result is sampled at the end of the cycle.
  - If 1: pc <= jump_target[ADDR_W-1:0] (zero-extended if ADDR_W>8), and branch_taken=1 during the following cycle only.
  - If 0: pc <= pc+1.
  - Next state is FETCH.
  - jump_target and reg3_value are sampled in the COND cycle, not earlier.
  - cond_opcode=0 outside COND; cond_operand is don't-care outside COND.
- HALT:
  - halted=1 and no requests are issued.
  - When halt=0, go to FETCH with pc unchanged.
- Halt asserted mid-instruction: the current instruction completes; halt takes effect only at the next FETCH entry.
- PC arithmetic is modulo 2^ADDR_W: 0xFF+1 wraps to 0x00. A jump target equal to the current PC is legal (tight loop).
- Minimum instruction latency with zero-wait memory and execute:
  - 3 cycles per non-conditional instruction (FETCH, WAIT, ISSUE).
  - 3 cycles per conditional instruction (FETCH, WAIT, COND).
- Invariant: at most one fetch outstanding; no new request is issued before the prior response is consumed.

Test Plan:
- Reset, memory always ready, rsp one cycle after req, program 0x00,0x41,0x82 at addresses 0..2, exec_ready=1 -> imem_addr sequence 0,1,2,3; instr_valid pulses carrying 0x00, 0x41, 0x82; branch_taken never asserts.
- Instruction 0xC4 (always) at pc=0x10, jump_target=0x37 -> cond_opcode=3'b100 in COND; next imem_addr=0x37; branch_taken high for exactly one cycle.
- Instruction 0xC1 (==0) with reg3_value=0x05, evaluator returns 0 -> pc advances 0x20→0x21, no branch_taken; repeat with reg3_value=0x00 and result 1 -> pc=jump_target.
- pc=0xFF with non-conditional instruction -> next fetch address 0x00.
- imem_req_ready held low 4 cycles, then exec_ready held low 3 cycles -> imem_addr/imem_req_valid stable through the wait, and instr/instr_valid stable through the exec stall; exactly one pc increment.
- halt raised during ISSUE -> the instruction retires, then halted=1 with no new request; halt dropped -> fetch resumes at the incremented pc. rst_n pulsed low during WAIT, followed by a late imem_rsp_valid -> response ignored, fetch restarts at RESET_PC.
